// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
//   - FSM state enum (IDLE, RUN, FIX)
//   - default operand width
//   - small op-decoding helpers
// Optional feature macro used by the unit: MDU_DIV_EN (divider datapath).
package mdu_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // op[1] selects divide, op[0] selects signed arithmetic.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: start/busy/done handshake and operand/result bus of the MDU.
//   master (control unit): drives start, op, rs_val, rt_val.
//   slave  (mdu)         : drives busy, done, err, hi, lo, state (debug view).
//
// Handshake: start is sampled only while the unit is IDLE, and op/rs_val/
// rt_val are read only in that same cycle. busy is high while an operation
// is in flight; done is a one-cycle pulse in which hi/lo/err are valid.
// start while busy is dropped (no queuing); start in the done cycle is taken.
interface mdu_if #(
  parameter int W = mdu_pkg::W_DEFAULT
);
  import mdu_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [W-1:0]     rs_val;
  logic [W-1:0]     rt_val;
  logic             busy;
  logic             done;
  logic             err;
  logic [W-1:0]     hi;
  logic [W-1:0]     lo;
  mdu_state_e       state;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, err, hi, lo, state
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, err, hi, lo, state
  );

endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: one restoring-divide iteration on unsigned magnitudes.
//   rem      in  W  partial remainder (always < divisor)
//   quo      in  W  dividend bits still to shift in / quotient bits so far
//   divisor  in  W  divisor magnitude (non-zero)
//   rem_next out W  updated partial remainder
//   quo_next out W  quo shifted left with the new quotient bit in bit 0
// Only instantiated when MDU_DIV_EN is defined.
module mdu_div_core #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         fits;

  assign shifted = {rem, quo[W-1]};
  assign fits    = (shifted >= {1'b0, divisor});
  // When the divisor fits, the true difference is below the divisor, so the
  // low W bits of a W-bit subtraction are exact.
  assign diff    = shifted[W-1:0] - divisor;

  assign rem_next = fits ? diff : shifted[W-1:0];
  assign quo_next = {quo[W-2:0], fits};

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply / restoring divide unit with HI/LO result regs.
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  mdu_if.slave: start/op/rs_val/rt_val in; busy/done/err/hi/lo/state out
// Latency: W+1 cycles for a normal op, 1 cycle for divide-by-zero.
// Build option: MDU_DIV_EN compiles in the divider; without it DIVU/DIV
// complete in one cycle with err=1 and hi/lo unchanged.
module mdu
  import mdu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam int CW = $clog2(W);

  mdu_state_e    state;
  logic [CW-1:0] count;
  logic [W-1:0]  m;        // multiplicand (mul) or divisor (div) magnitude
  logic [2*W:0]  p;        // mul: {acc_hi, multiplier}; div: {rem, quotient}
  logic          neg_res;  // negate product / quotient in FIX
  logic          err_pend;
  logic          busy_r, done_r, err_r;
  logic [W-1:0]  hi_r, lo_r;

  // Operand magnitudes; W bits hold 2^(W-1) exactly as an unsigned value.
  logic         sgn;
  logic [W-1:0] rs_mag, rt_mag;
  assign sgn    = op_is_signed(bus.op);
  assign rs_mag = (sgn && bus.rs_val[W-1]) ? -bus.rs_val : bus.rs_val;
  assign rt_mag = (sgn && bus.rt_val[W-1]) ? -bus.rt_val : bus.rt_val;

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [W:0]   mul_sum;
  logic [2*W:0] mul_next;
  logic [2*W-1:0] prod_fix;
  assign mul_sum  = p[2*W:W] + {1'b0, (p[0] ? m : '0)};
  assign mul_next = {1'b0, mul_sum, p[W-1:1]};
  assign prod_fix = neg_res ? -p[2*W-1:0] : p[2*W-1:0];

`ifdef MDU_DIV_EN
  logic         div_r;
  logic         neg_r;     // remainder follows the dividend's sign
  logic [W-1:0] div_rem, div_quo;
  logic [W-1:0] quo_fix, rem_fix;

  mdu_div_core #(.W(W)) u_div_core (
    .rem      (p[2*W-1:W]),
    .quo      (p[W-1:0]),
    .divisor  (m),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  assign quo_fix = neg_res ? -p[W-1:0] : p[W-1:0];
  assign rem_fix = neg_r ? -p[2*W-1:W] : p[2*W-1:W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      m        <= '0;
      p        <= '0;
      neg_res  <= 1'b0;
      err_pend <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
`ifdef MDU_DIV_EN
      div_r    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            count    <= '0;
            err_pend <= 1'b0;
            if (op_is_div(bus.op)) begin
`ifdef MDU_DIV_EN
              div_r   <= 1'b1;
              neg_res <= sgn && (bus.rs_val[W-1] ^ bus.rt_val[W-1]);
              neg_r   <= sgn && bus.rs_val[W-1];
              m       <= rt_mag;
              p       <= {{(W+1){1'b0}}, rs_mag};
              if (bus.rt_val == '0) begin
                err_pend <= 1'b1;
                state    <= FIX;
              end else begin
                state    <= RUN;
              end
`else
              // No divider in this build: report as an error in one cycle.
              err_pend <= 1'b1;
              state    <= FIX;
`endif
            end else begin
`ifdef MDU_DIV_EN
              div_r   <= 1'b0;
`endif
              neg_res <= sgn && (bus.rs_val[W-1] ^ bus.rt_val[W-1]);
              m       <= rs_mag;
              p       <= {{(W+1){1'b0}}, rt_mag};
              state   <= RUN;
            end
          end
        end
        RUN: begin
          busy_r <= 1'b1;
          count  <= count + CW'(1);
`ifdef MDU_DIV_EN
          if (div_r) p <= {1'b0, div_rem, div_quo};
          else
`endif
          p <= mul_next;
          if (count == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (err_pend) begin
            err_r <= 1'b1;
          end
`ifdef MDU_DIV_EN
          else if (div_r) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end
`endif
          else begin
            hi_r <= prod_fix[2*W-1:W];
            lo_r <= prod_fix[W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.state = state;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. A reference model computes results
// with plain 64-bit arithmetic and tracks the expected timing; a negedge
// process compares every output each cycle. Directed cases pin literal values.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mdu_if #(.W(W)) bus ();

  mdu #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters / compare ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result word: {err, hi, lo}.
  function automatic logic [2*W:0] ref_result(input logic [1:0] o,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [63:0] ua, ub, r64, q64;
    longint sa, sb, sq, sr;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: return {1'b0, ua * ub};
      2'b01: begin
        sq = sa * sb;
        return {1'b0, 64'(sq)};
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b == '0) return {1'b1, 64'b0};
        if (o == 2'b10) begin
          q64 = ua / ub;
          r64 = ua % ub;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = 64'(sq);
          r64 = 64'(sr);
        end
        return {1'b0, r64[31:0], q64[31:0]};
`else
        return {1'b1, 64'b0};
`endif
      end
    endcase
  endfunction

  logic [2*W:0] exp_q[$];
  bit           m_active = 0;
  int           m_cnt = 0;
  int           m_total = 0;
  logic         m_busy = 0, m_done = 0, m_err = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  bit           chk_en = 0;

  always @(posedge clk) begin
    logic [2*W:0] e;
    if (rst) begin
      m_active = 0; m_cnt = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_hi = '0; m_lo = '0;
      exp_q.delete();
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_active) begin
        m_cnt++;
        if (m_cnt == m_total) begin
          m_active = 0;
          m_busy = 0;
          m_done = 1;
          e = exp_q.pop_front();
          m_err = e[2*W];
          if (!m_err) begin
            m_hi = e[2*W-1:W];
            m_lo = e[W-1:0];
          end
        end else begin
          m_busy = 1;
        end
      end else if (bus.start) begin
        e = ref_result(bus.op, bus.rs_val, bus.rt_val);
        exp_q.push_back(e);
        m_active = 1;
        m_cnt = 0;
        m_total = e[2*W] ? 1 : W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
      if (m_done) check("err", 64'(bus.err), 64'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves start low one cycle later with scrambled operands.
  task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = 2'($urandom_range(0, 3));
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  // lat counts edges after the start edge; p1/p2 inject ignored start pulses.
  task automatic wait_done(input int p1, input int p2, output int lat, output int bcyc);
    lat = 0;
    bcyc = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcyc++;
      bus.start = (lat == p1 || lat == p2) && !bus.done;
      if (bus.start) bus.op = 2'($urandom_range(0, 3));
    end
    bus.start = 1'b0;
    check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic run_lit(input string name, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_err,
                         input int p1, input int p2, output int bcyc);
    int lat;
    drive_start(o, a, b);
    wait_done(p1, p2, lat, bcyc);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check({name, "_err"}, 64'(bus.err), 64'(exp_err));
  endtask

  task automatic quiet(input int n, input string name);
    int d = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) d++;
    end
    check(name, 64'(d), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_hi"}, 64'(bus.hi), 64'd0);
    check({name, "_lo"}, 64'(bus.lo), 64'd0);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_done"}, 64'(bus.done), 64'd0);
    check({name, "_err"}, 64'(bus.err), 64'd0);
    check({name, "_state"}, 64'(bus.state), 64'(IDLE));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_lit("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0, bc);
    run_lit("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 0, bc);
    check("mult_busy_cycles", 64'(bc), 64'd32);
`ifdef MDU_DIV_EN
    run_lit("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0, bc);
    run_lit("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'h0, 32'h8000_0000, 1'b0, 0, 0, bc);
`else
    run_lit("div_off", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 0, 0, bc);
`endif
    // 0x22 * 0x80000001 = 0x11_00000022
    run_lit("preload", OP_MULTU, 32'h22, 32'h8000_0001, 33,
            32'h11, 32'h22, 1'b0, 0, 0, bc);
    run_lit("divu_zero", OP_DIVU, 32'd100, 32'd0, 1,
            32'h11, 32'h22, 1'b1, 0, 0, bc);
    check("divu_zero_busy", 64'(bc), 64'd0);

    run_lit("multu_pokes", OP_MULTU, 32'd3, 32'd4, 33,
            32'h0, 32'd12, 1'b0, 5, 20, bc);
    quiet(40, "pokes_no_extra_done");

    // Reset in the middle of an operation.
    drive_start(OP_MULTU, $urandom, $urandom);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");
    quiet(40, "mid_rst_no_done");

    run_lit("multu_6x7", OP_MULTU, 32'd6, 32'd7, 33,
            32'h0, 32'd42, 1'b0, 0, 0, bc);
`ifdef MDU_DIV_EN
    run_lit("divu_10_2", OP_DIVU, 32'd10, 32'd2, 33,
            32'h0, 32'd5, 1'b0, 0, 0, bc);
`else
    run_lit("divu_10_2", OP_DIVU, 32'd10, 32'd2, 1,
            32'h0, 32'd42, 1'b1, 0, 0, bc);
`endif

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    quiet(40, "rst_start_no_done");
    check_zero("rst_start");

    // Randomized operations; without a gap the next start lands in the done cycle.
    for (int i = 0; i < 40; i++) begin
      int lat;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      drive_start(2'($urandom_range(0, 3)), pick(), pick());
      wait_done(0, 0, lat, bc);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
